// File: rtl/seq_digit_mult_pkg.sv
// Shared definitions for the sequential digit multiplier.
//   DIG_W   : width of one operand digit (the multiplier cell works on 2-bit digits)
//   state_t : controller states IDLE / BUSY / DONE
package seq_digit_mult_pkg;

    localparam int DIG_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_digit_mult_digit_mult2x2.sv
// Combinational 2-bit x 2-bit unsigned multiplier cell.
// Ports:
//   a, b : 2-bit unsigned digits
//   p    : 4-bit unsigned product
// Kept as its own module so a different cell implementation can be dropped in
// without touching the controller.
module digit_mult2x2
    import seq_digit_mult_pkg::*;
(
    input  logic [DIG_W-1:0]   a,
    input  logic [DIG_W-1:0]   b,
    output logic [2*DIG_W-1:0] p
);

    logic pp_00, pp_10, pp_01, pp_11;
    logic carry_1;

    assign pp_00 = a[0] & b[0];
    assign pp_10 = a[1] & b[0];
    assign pp_01 = a[0] & b[1];
    assign pp_11 = a[1] & b[1];

    // Half-adder chain over the partial-product columns.
    assign carry_1 = pp_10 & pp_01;
    assign p[0]    = pp_00;
    assign p[1]    = pp_10 ^ pp_01;
    assign p[2]    = pp_11 ^ carry_1;
    assign p[3]    = pp_11 & carry_1;

endmodule

// File: rtl/seq_digit_mult.sv
// Sequential WIDTH x WIDTH multiplier with valid/ready handshakes.
// Both operands are split into 2-bit digits; one 2x2 cell is reused once per
// cycle and the shifted digit products are accumulated into a 2*WIDTH result.
// Signed operation (tc=1) multiplies magnitudes and negates the result at the end.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (A, B, tc sampled on acceptance)
//   A, B, tc             : operands and two's-complement mode
//   out_valid / out_ready: product handshake
//   P                    : 2*WIDTH-bit product
//   busy                 : high while digit products are being accumulated
module seq_digit_mult
    import seq_digit_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               tc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);

    localparam int DIGITS = WIDTH / DIG_W;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SH_W   = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("seq_digit_mult: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t state_reg, state_next;

    logic [WIDTH-1:0]   a_mag_reg, b_mag_reg;
    logic               neg_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] p_reg;
    logic [IDX_W-1:0]   i_reg, j_reg;

    logic               accept;
    logic               last_step;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in;
    logic [DIG_W-1:0]   a_digs [DIGITS];
    logic [DIG_W-1:0]   b_digs [DIGITS];
    logic [DIG_W-1:0]   a_dig, b_dig;
    logic [2*DIG_W-1:0] cell_prod;
    logic [2*WIDTH-1:0] prod_ext;
    logic [2*WIDTH-1:0] acc_sum;
    logic [SH_W-1:0]    shift_amt;

    // Magnitudes: -2^(WIDTH-1) negates to itself, which is the correct
    // unsigned magnitude in WIDTH bits.
    assign a_mag_in = (tc && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign b_mag_in = (tc && B[WIDTH-1]) ? (~B + 1'b1) : B;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digits
        assign a_digs[gi] = a_mag_reg[gi*DIG_W +: DIG_W];
        assign b_digs[gi] = b_mag_reg[gi*DIG_W +: DIG_W];
    end

    assign a_dig = a_digs[i_reg];
    assign b_dig = b_digs[j_reg];

    digit_mult2x2 u_cell (
        .a (a_dig),
        .b (b_dig),
        .p (cell_prod)
    );

    always_comb begin
        prod_ext = '0;
        prod_ext[2*DIG_W-1:0] = cell_prod;
    end

    // Digit product weight is 4^(i+j), i.e. a left shift of 2*(i+j).
    assign shift_amt = {1'b0, i_reg, 1'b0} + {1'b0, j_reg, 1'b0};
    assign acc_sum   = acc_reg + (prod_ext << shift_amt);
    assign last_step = (i_reg == LAST_IDX) && (j_reg == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_mag_reg <= '0;
            b_mag_reg <= '0;
            neg_reg   <= 1'b0;
            acc_reg   <= '0;
            p_reg     <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
        end else if (accept) begin
            a_mag_reg <= a_mag_in;
            b_mag_reg <= b_mag_in;
            neg_reg   <= tc & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc_reg   <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
        end else if (busy) begin
            acc_reg <= acc_sum;
            if (j_reg == LAST_IDX) begin
                j_reg <= '0;
                i_reg <= i_reg + 1'b1;
            end else begin
                j_reg <= j_reg + 1'b1;
            end
            // Negating a zero sum yields zero, so no special case is needed.
            if (last_step) begin
                p_reg <= neg_reg ? (~acc_sum + 1'b1) : acc_sum;
            end
        end
    end

    assign P = p_reg;

endmodule

// File: tb/tb_seq_digit_mult.sv
module tb_seq_digit_mult;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv8, ir8, tc8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        iv4, ir4, tc4, ov4, or4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    seq_digit_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .tc(tc8), .out_valid(ov8), .out_ready(or8),
        .P(p8), .busy(busy8)
    );

    seq_digit_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .A(a4), .B(b4), .tc(tc4), .out_valid(ov4), .out_ready(or4),
        .P(p4), .busy(busy4)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference product: plain integer multiply of the operands interpreted as
    // unsigned or two's complement, reduced to 2*w bits.
    function automatic logic [31:0] ref_prod(input int w, input logic [15:0] a,
                                             input logic [15:0] b, input logic t);
        longint mask, sa, sb, pr;
        mask = (longint'(1) << w) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (t && sa[w-1]) sa = sa - (longint'(1) << w);
        if (t && sb[w-1]) sb = sb - (longint'(1) << w);
        pr = sa * sb;
        pr = pr & ((longint'(1) << (2 * w)) - 1);
        return 32'(pr);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every cycle, compare outputs with the model queue.
    logic [15:0] q8[$];
    logic [7:0]  q4[$];
    int acc_cyc8 = 0, acc_cyc4 = 0;
    logic pov8 = 1'b0, pov4 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q8.delete();
            q4.delete();
            pov8 = 1'b0;
            pov4 = 1'b0;
        end else begin
            chk("mon_busy8", 32'(busy8), 32'((q8.size() > 0) && !ov8));
            if (ov8) begin
                chk("mon_ready_vs_valid8", 32'(ir8), 32'(0));
                if (q8.size() == 0) begin
                    chk("mon_spurious8", 32'(ov8), 32'(0));
                end else begin
                    chk("mon_p8", 32'(p8), 32'(q8[0]));
                    if (!pov8) chk("mon_latency8", 32'(cyc - acc_cyc8 - 1), 32'(16));
                    if (or8) void'(q8.pop_front());
                end
            end
            if (iv8 && ir8) begin
                q8.push_back(16'(ref_prod(8, 16'(a8), 16'(b8), tc8)));
                acc_cyc8 = cyc;
            end
            pov8 = ov8;

            chk("mon_busy4", 32'(busy4), 32'((q4.size() > 0) && !ov4));
            if (ov4) begin
                chk("mon_ready_vs_valid4", 32'(ir4), 32'(0));
                if (q4.size() == 0) begin
                    chk("mon_spurious4", 32'(ov4), 32'(0));
                end else begin
                    chk("mon_p4", 32'(p4), 32'(q4[0]));
                    if (!pov4) chk("mon_latency4", 32'(cyc - acc_cyc4 - 1), 32'(4));
                    if (or4) void'(q4.pop_front());
                end
            end
            if (iv4 && ir4) begin
                q4.push_back(8'(ref_prod(4, 16'(a4), 16'(b4), tc4)));
                acc_cyc4 = cyc;
            end
            pov4 = ov4;
        end
    end

    task automatic xact8(input logic [7:0] a, input logic [7:0] b, input logic t,
                         input int hold, input logic [15:0] exp, input string name);
        int n;
        n = 0;
        while (!ir8 && n < 50) begin @(posedge clk); #1; n++; end
        chk({name, "_in_ready"}, 32'(ir8), 32'(1));
        a8 = a; b8 = b; tc8 = t; iv8 = 1'b1; or8 = (hold == 0);
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); tc8 = 1'($urandom);
        n = 0;
        while (!ov8 && n < 100) begin @(posedge clk); #1; n++; end
        chk({name, "_latency"}, 32'(n), 32'(16));
        chk({name, "_p"}, 32'(p8), 32'(exp));
        for (int k = 0; k < hold; k++) begin
            iv8 = k[0]; a8 = 8'($urandom);
            @(posedge clk); #1;
            chk({name, "_hold_valid"}, 32'(ov8), 32'(1));
            chk({name, "_hold_p"}, 32'(p8), 32'(exp));
            chk({name, "_hold_ready"}, 32'(ir8), 32'(0));
        end
        iv8 = 1'b0; or8 = 1'b1;
        @(posedge clk); #1;
        chk({name, "_post_valid"}, 32'(ov8), 32'(0));
        chk({name, "_post_ready"}, 32'(ir8), 32'(1));
        $display("xact8 %s: A=%02h B=%02h tc=%0d P=%04h expected %04h", name, a, b, t, p8, exp);
    endtask

    task automatic xact4(input logic [3:0] a, input logic [3:0] b, input logic t,
                         input logic [7:0] exp, input string name, input bit verbose);
        int n;
        n = 0;
        while (!ir4 && n < 50) begin @(posedge clk); #1; n++; end
        chk({name, "_in_ready"}, 32'(ir4), 32'(1));
        a4 = a; b4 = b; tc4 = t; iv4 = 1'b1; or4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        n = 0;
        while (!ov4 && n < 100) begin @(posedge clk); #1; n++; end
        chk({name, "_latency"}, 32'(n), 32'(4));
        chk({name, "_p"}, 32'(p4), 32'(exp));
        @(posedge clk); #1;
        chk({name, "_post_valid"}, 32'(ov4), 32'(0));
        if (verbose)
            $display("xact4 %s: A=%01h B=%01h tc=%0d P=%02h expected %02h", name, a, b, t, p4, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        iv8 = 1'b0; tc8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
        iv4 = 1'b0; tc4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready8", 32'(ir8), 32'(1));
        chk("rst_out_valid8", 32'(ov8), 32'(0));
        chk("rst_busy8", 32'(busy8), 32'(0));
        chk("rst_p8", 32'(p8), 32'(0));
        chk("rst_in_ready4", 32'(ir4), 32'(1));
        chk("rst_p4", 32'(p4), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the model with hand-computed products.
        chk("model_13x11", ref_prod(8, 16'd13, 16'd11, 1'b0), 32'h008F);
        chk("model_m3x5", ref_prod(8, 16'hFD, 16'd5, 1'b1), 32'hFFF1);
        chk("model_m128sq", ref_prod(8, 16'h80, 16'h80, 1'b1), 32'h4000);
        chk("model4_m8sq", ref_prod(4, 16'h8, 16'h8, 1'b1), 32'h40);

        xact8(8'd13,  8'd11,  1'b0, 0, 16'h008F, "u13x11");
        xact8(8'd255, 8'd255, 1'b0, 0, 16'hFE01, "u255x255");
        xact8(8'h80,  8'h80,  1'b1, 0, 16'h4000, "s_m128x_m128");
        xact8(8'hFD,  8'd5,   1'b1, 0, 16'hFFF1, "s_m3x5");
        xact8(8'd0,   8'hF9,  1'b1, 0, 16'h0000, "s_0x_m7");
        xact8(8'd7,   8'd9,   1'b0, 10, 16'd63,  "backpressure");

        // Reset in the 7th BUSY cycle abandons the transaction.
        a8 = 8'd200; b8 = 8'd100; tc8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("pre_rst_busy8", 32'(busy8), 32'(1));
        rst = 1'b1;
        #1;
        chk("async_rst_valid8", 32'(ov8), 32'(0));
        chk("async_rst_busy8", 32'(busy8), 32'(0));
        chk("async_rst_ready8", 32'(ir8), 32'(1));
        chk("async_rst_p8", 32'(p8), 32'(0));
        $display("reset mid-op: busy=%0d in_ready=%0d out_valid=%0d P=%04h", busy8, ir8, ov8, p8);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abandoned_no_output8", 32'(ov8), 32'(0));
        xact8(8'd2, 8'd3, 1'b0, 0, 16'd6, "after_reset");

        // WIDTH=4 instance.
        xact4(4'd15, 4'd15, 1'b0, 8'd225, "w4_15x15", 1'b1);
        xact4(4'h8,  4'h8,  1'b1, 8'h40,  "w4_s_m8x_m8", 1'b1);
        for (int t = 0; t < 2; t++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    xact4(4'(a), 4'(b), 1'(t),
                          8'(ref_prod(4, 16'(a), 16'(b), 1'(t))), "w4_sweep", 1'b0);
                end
            end
            $display("w4 sweep tc=%0d: 256 pairs issued", t);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
